cov_accumulate: RTL and testbench
=================================

# cov_accumulate

Streaming covariance estimator that sits directly upstream of the eigen-decomposition stage. It accepts one multichannel ECG sample vector per handshake and accumulates first and second moments over a fixed window of NUM_SAMPLES vectors. It then produces the SIZE_N x SIZE_N integer covariance matrix consumed as `cov_matrix` by `find_eigen`. The matrix is held stable with `cov_valid` high until the next `start`.

## Interface
- SIZE_N, 8, number of channels (matrix dimension)
- LOG2_SAMPLES, 8, window length is NUM_SAMPLES = 2**LOG2_SAMPLES; legal range 1..16
- DATA_W, 16, signed sample width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (rst == 0 resets)
- start  in  1  single-cycle pulse; clears accumulators and opens a new window
- sample_valid  in  1  sample vector present
- sample_ready  out  1  block can take a vector this cycle
- sample  in  [SIZE_N] x DATA_W signed  one value per channel
- cov_matrix  out  integer [SIZE_N][SIZE_N]  result, row-major
- cov_valid  out  1  cov_matrix complete and stable
- busy  out  1  window open or finalising

## Operation
- States: IDLE, LOAD, MAC, FINAL, DONE.
- Reset: state IDLE. All outputs are 0: sample_ready, cov_valid, busy, and every cov_matrix element. Accumulators and counters are 0.
- In IDLE or DONE, `start` does the following on the next edge:
  - clears the 64-bit accumulators S[r][c] and m[r], and the sample counter;
  - clears cov_valid;
  - moves to LOAD.
- `start` in LOAD, MAC or FINAL is ignored.
- LOAD:
  - sample_ready = 1.
  - On sample_valid && sample_ready, the vector is latched into x[] and the state moves to MAC.
- MAC runs SIZE_N cycles, row r = 0..SIZE_N-1, one row per cycle:
  - S[r][c] += x[r]*x[c] for all c;
  - m[r] += x[r].
- After row SIZE_N-1, the sample counter increments.
  - Counter == NUM_SAMPLES: go to FINAL.
  - Otherwise: return to LOAD.
- FINAL runs SIZE_N*SIZE_N cycles and writes one element per cycle in row-major order (k = r*SIZE_N + c).
  - cov[r][c] = (S[r][c] - ((m[r]*m[c]) >>> L)) >>> L, where L = LOG2_SAMPLES and >>> is an arithmetic shift.
  - The result saturates to the signed 32-bit range.
- DONE:
  - cov_valid = 1 and busy = 0.
  - cov_matrix holds until the next start.
- Arithmetic:
  - Products are 2*DATA_W signed.
  - Accumulators are 64-bit signed; they do not overflow for DATA_W ≤ 16 and L ≤ 16.
  - m[r]*m[c] is computed in 64 bits.
- Output symmetry: cov[r][c] equals cov[c][r] bit-exactly.
- busy = 1 in LOAD, MAC and FINAL.

## Timing
- Handshake:
  - A transfer occurs on an edge where sample_valid && sample_ready.
  - sample_ready deasserts the cycle after a transfer.
  - The source must hold sample stable while sample_valid && !sample_ready.
- Throughput: one vector per SIZE_N+1 cycles (1 LOAD cycle + SIZE_N MAC cycles) when the source is always valid.
- Latency from the last transfer to cov_valid = SIZE_N (MAC) + SIZE_N*SIZE_N (FINAL) + 1 cycles. With defaults: 8 + 64 + 1 = 73.
- cov_matrix elements update during FINAL. They are only meaningful while cov_valid = 1.
- start and sample_valid in the same cycle in IDLE: start wins; the sample is not taken, because sample_ready = 0 in IDLE.
- Reset asserted in any state:
  - returns to IDLE immediately (asynchronously);
  - clears cov_matrix;
  - the partial window is discarded.
- sample_valid while in MAC, FINAL or DONE: no transfer; the source keeps waiting.

## Configuration
- COV_MEAN_REMOVAL_EN
  - Defined: the mean term ((m[r]*m[c]) >>> L) is subtracted as above, giving the true covariance.
  - Undefined: the m[] accumulators and their multiplier are not built, and cov[r][c] = S[r][c] >>> L (raw second moment).
  - Cycle timing is identical in both builds.

## Test plan
- Reset, then idle 10 cycles:
  - all outputs 0;
  - sample_ready = 0;
  - cov_valid = 0.
- Zero-mean vectors, LOG2_SAMPLES = 2, SIZE_N = 2; samples {1,2}, {-1,-2}, {1,2}, {-1,-2} with sample_valid held high:
  - cov = [[1,2],[2,4]] in both builds;
  - cov_valid rises exactly 2+4+1 = 7 cycles after the 4th transfer.
- Constant vectors {3,5} ×4, LOG2_SAMPLES = 2, SIZE_N = 2:
  - with COV_MEAN_REMOVAL_EN: cov = [[0,0],[0,0]];
  - without: cov = [[9,15],[15,25]].
- Bursty source with sample_valid toggling randomly, SIZE_N = 8, full-scale ±32767 samples:
  - each transfer occurs only when sample_ready = 1;
  - a sample is never lost or duplicated;
  - results match a golden model;
  - cov_matrix is symmetric.
- start pulsed during MAC and during FINAL: ignored; the window completes with the unchanged result. start in DONE clears cov_valid on the next edge.
- rst asserted mid-window (after 2 of 4 samples), released, then start and a fresh window of 4 samples: the result reflects only the new 4 samples.

Source files
------------

// File: rtl/cov_accumulate_if.sv
// cov_accumulate_if: sample-vector handshake and covariance result bundle
// for cov_accumulate. The master side is the sample source / result
// consumer; the slave side is the estimator itself.
interface cov_accumulate_if #(
  parameter int SIZE_N = 8,
  parameter int DATA_W = 16
);
  logic                                 start;
  logic                                 sample_valid;
  logic                                 sample_ready;
  logic [SIZE_N-1:0][DATA_W-1:0]        sample;
  logic [SIZE_N-1:0][SIZE_N-1:0][31:0]  cov_matrix;
  logic                                 cov_valid;
  logic                                 busy;

  modport master (
    output start, sample_valid, sample,
    input  sample_ready, cov_matrix, cov_valid, busy
  );

  modport slave (
    input  start, sample_valid, sample,
    output sample_ready, cov_matrix, cov_valid, busy
  );
endinterface

// File: rtl/cov_accumulate.sv
// cov_accumulate: streaming covariance estimator over a window of
// 2**LOG2_SAMPLES sample vectors. Each accepted vector is folded into the
// second-moment accumulators one matrix row per cycle, then the matrix is
// finalised one element per cycle in row-major order.
// Optional feature macro: COV_MEAN_REMOVAL_EN (subtract the mean term,
// giving true covariance instead of the raw second moment).
module cov_accumulate #(
  parameter int SIZE_N       = 8,
  parameter int LOG2_SAMPLES = 8,
  parameter int DATA_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  cov_accumulate_if.slave   bus
);

  localparam int IW = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
  localparam int CW = LOG2_SAMPLES + 1;
  localparam logic [IW-1:0] ROW_LAST = IW'(SIZE_N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((64'd1 << LOG2_SAMPLES) - 64'd1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic                 ready_q, busy_q, valid_q;
  logic [IW-1:0]        row_q, col_q;
  logic [CW-1:0]        cnt_q;
  logic signed [DATA_W-1:0] x_q [SIZE_N];
  logic signed [63:0]   s_q [SIZE_N][SIZE_N];
`ifdef COV_MEAN_REMOVAL_EN
  logic signed [63:0]   m_q [SIZE_N];
`endif
  logic [SIZE_N-1:0][SIZE_N-1:0][31:0] cov_q;

  logic signed [2*DATA_W-1:0] prod_s [SIZE_N];
  logic signed [63:0]   mean_s, diff_s, shr_s;
  logic signed [31:0]   elem_s;

  // Clamp a 64-bit signed value into the signed 32-bit range.
  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sd2147483647) begin
      sat32 = 32'sh7FFF_FFFF;
    end else if (v < -64'sd2147483648) begin
      sat32 = 32'sh8000_0000;
    end else begin
      sat32 = v[31:0];
    end
  endfunction

  // Next-state decode; start is only honoured in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD;
        else           state_d = IDLE;
      end
      LOAD: begin
        if (bus.sample_valid && ready_q) state_d = MAC;
        else                             state_d = LOAD;
      end
      MAC: begin
        if (row_q == ROW_LAST) begin
          if (cnt_q == CNT_LAST) state_d = FINAL;
          else                   state_d = LOAD;
        end else begin
          state_d = MAC;
        end
      end
      FINAL: begin
        if ((row_q == ROW_LAST) && (col_q == ROW_LAST)) state_d = DONE;
        else                                            state_d = FINAL;
      end
      DONE: begin
        if (bus.start) state_d = LOAD;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One row of outer-product terms x[row]*x[c] for the current MAC cycle.
  always_comb begin
    for (int c = 0; c < SIZE_N; c++) begin
      prod_s[c] = x_q[row_q] * x_q[c];
    end
  end

  // Element finalisation: optional mean removal, scale by window, clamp.
  always_comb begin
`ifdef COV_MEAN_REMOVAL_EN
    mean_s = (m_q[row_q] * m_q[col_q]) >>> LOG2_SAMPLES;
`else
    mean_s = 64'sd0;
`endif
    diff_s = s_q[row_q][col_q] - mean_s;
    shr_s  = diff_s >>> LOG2_SAMPLES;
    elem_s = sat32(shr_s);
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == LOAD);
      busy_q  <= (state_d == LOAD) || (state_d == MAC) || (state_d == FINAL);
      valid_q <= (state_d == DONE);
    end
  end

  // Datapath: vector latch, moment accumulation, counters, result writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
      cov_q <= '0;
      for (int r = 0; r < SIZE_N; r++) begin
        x_q[r] <= '0;
`ifdef COV_MEAN_REMOVAL_EN
        m_q[r] <= 64'sd0;
`endif
        for (int c = 0; c < SIZE_N; c++) s_q[r][c] <= 64'sd0;
      end
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            row_q <= '0;
            col_q <= '0;
            cnt_q <= '0;
            for (int r = 0; r < SIZE_N; r++) begin
`ifdef COV_MEAN_REMOVAL_EN
              m_q[r] <= 64'sd0;
`endif
              for (int c = 0; c < SIZE_N; c++) s_q[r][c] <= 64'sd0;
            end
          end
        end
        LOAD: begin
          if (bus.sample_valid && ready_q) begin
            for (int c = 0; c < SIZE_N; c++) x_q[c] <= bus.sample[c];
            row_q <= '0;
          end
        end
        MAC: begin
          for (int c = 0; c < SIZE_N; c++) begin
            s_q[row_q][c] <= s_q[row_q][c] + 64'(prod_s[c]);
          end
`ifdef COV_MEAN_REMOVAL_EN
          m_q[row_q] <= m_q[row_q] + 64'(x_q[row_q]);
`endif
          if (row_q == ROW_LAST) begin
            row_q <= '0;
            col_q <= '0;
            cnt_q <= cnt_q + CW'(1);
          end else begin
            row_q <= row_q + IW'(1);
          end
        end
        FINAL: begin
          cov_q[row_q][col_q] <= elem_s;
          if (col_q == ROW_LAST) begin
            col_q <= '0;
            if (row_q == ROW_LAST) row_q <= '0;
            else                   row_q <= row_q + IW'(1);
          end else begin
            col_q <= col_q + IW'(1);
          end
        end
        default: begin
          row_q <= '0;
          col_q <= '0;
        end
      endcase
    end
  end

  assign bus.sample_ready = ready_q;
  assign bus.busy         = busy_q;
  assign bus.cov_valid    = valid_q;
  assign bus.cov_matrix   = cov_q;

endmodule

// File: tb/tb_cov_accumulate.sv
// tb_cov_accumulate: scoreboard bench. A small 2x2 instance checks the
// directed windows (latency, ignored starts, reset mid-window); an 8x8
// instance takes bursty full-scale random windows. Expected matrices are
// computed from the sample lists with plain arithmetic and queued; monitors
// pop and compare when cov_valid rises.
module tb_cov_accumulate;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cov_accumulate_if #(.SIZE_N(2), .DATA_W(16)) ifa ();
  cov_accumulate_if #(.SIZE_N(8), .DATA_W(16)) ifb ();

  cov_accumulate #(.SIZE_N(2), .LOG2_SAMPLES(2), .DATA_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  cov_accumulate #(.SIZE_N(8), .LOG2_SAMPLES(4), .DATA_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  int n_vec = 0;
  int n_err = 0;
  longint exp_a_q[$];
  longint exp_b_q[$];
  logic a_prev = 1'b0;
  logic b_prev = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: sums over the window, then (S - (m*m >>> L)) >>> L, clamped.
  function automatic void cov_model(input longint xs[$], input int n, input int l,
                                    output longint res[$]);
    longint s[];
    longint m[];
    int nv;
    s = new[n*n];
    m = new[n];
    res = {};
    nv = xs.size() / n;
    for (int v = 0; v < nv; v++)
      for (int r = 0; r < n; r++) begin
        m[r] += xs[v*n+r];
        for (int c = 0; c < n; c++) s[r*n+c] += xs[v*n+r] * xs[v*n+c];
      end
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        longint t;
        t = s[r*n+c];
`ifdef COV_MEAN_REMOVAL_EN
        t = t - ((m[r] * m[c]) >>> l);
`endif
        t = t >>> l;
        if (t > 64'sd2147483647) t = 64'sd2147483647;
        if (t < -64'sd2147483648) t = -64'sd2147483648;
        res.push_back(t);
      end
  endfunction

  // Monitor for the 2x2 instance.
  always @(negedge clk) begin
    if (ifa.cov_valid === 1'b1 && !a_prev) begin
      if (exp_a_q.size() < 4) check("a_unexpected_result", 64'sd1, 64'sd0);
      else
        for (int k = 0; k < 4; k++) begin
          longint e;
          e = exp_a_q.pop_front();
          check($sformatf("a_cov[%0d][%0d]", k/2, k%2),
                $signed(ifa.cov_matrix[k/2][k%2]), e);
        end
    end
    a_prev <= ifa.cov_valid;
  end

  // Monitor for the 8x8 instance: values plus symmetry.
  always @(negedge clk) begin
    if (ifb.cov_valid === 1'b1 && !b_prev) begin
      if (exp_b_q.size() < 64) check("b_unexpected_result", 64'sd1, 64'sd0);
      else begin
        for (int k = 0; k < 64; k++) begin
          longint e;
          e = exp_b_q.pop_front();
          check($sformatf("b_cov[%0d][%0d]", k/8, k%8),
                $signed(ifb.cov_matrix[k/8][k%8]), e);
        end
        for (int r = 0; r < 8; r++)
          for (int c = r + 1; c < 8; c++)
            check($sformatf("b_sym[%0d][%0d]", r, c),
                  $signed(ifb.cov_matrix[r][c]), $signed(ifb.cov_matrix[c][r]));
      end
    end
    b_prev <= ifb.cov_valid;
  end

  // Feed one 2-sample vector and wait until it is accepted.
  task automatic a_feed(input int v0, input int v1);
    int n;
    ifa.sample[0] = 16'(v0);
    ifa.sample[1] = 16'(v1);
    ifa.sample_valid = 1'b1;
    n = 0;
    while (ifa.sample_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("a_ready_timeout", 64'sd0, 64'sd1);
  endtask

  // One 4-vector window on the 2x2 instance; mode 1/2 pulses start in MAC/FINAL.
  task automatic run_a(input int vals[8], input int mode);
    longint xs[$];
    longint res[$];
    int n;
    for (int i = 0; i < 8; i++) xs.push_back(vals[i]);
    cov_model(xs, 2, 2, res);
    foreach (res[i]) exp_a_q.push_back(res[i]);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    check("a_start_clears_valid", ifa.cov_valid, 64'sd0);
    check("a_busy_after_start", ifa.busy, 64'sd1);
    for (int v = 0; v < 4; v++) begin
      a_feed(vals[2*v], vals[2*v+1]);
      if (v < 3) @(negedge clk);
    end
    n = 0;
    while (ifa.cov_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        ifa.sample[0] = 16'(99);
        ifa.sample[1] = 16'(-99);
      end
      ifa.start = ((mode == 1) && (n == 1)) || ((mode == 2) && (n == 4));
    end
    ifa.start = 1'b0;
    check("a_latency", n, 64'sd7);
    check("a_done_busy", ifa.busy, 64'sd0);
    check("a_done_ready", ifa.sample_ready, 64'sd0);
    ifa.sample_valid = 1'b0;
    @(negedge clk);
  endtask

  // One bursty full-scale window on the 8x8 instance.
  task automatic run_b();
    longint xs[$];
    longint res[$];
    int idx, cyc, n, sel;
    bit just;
    for (int i = 0; i < 128; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      xs.push_back(32767);
      else if (sel == 1) xs.push_back(-32767);
      else               xs.push_back(longint'(int'($urandom_range(0, 65534)) - 32767));
    end
    cov_model(xs, 8, 4, res);
    foreach (res[i]) exp_b_q.push_back(res[i]);
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    ifb.sample_valid = 1'b0;
    idx = 0;
    cyc = 0;
    just = 1'b0;
    while (idx < 16 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (just) begin
        ifb.sample_valid = 1'b0;
        just = 1'b0;
      end
      if (!ifb.sample_valid && ($urandom_range(0, 2) != 0)) begin
        for (int r = 0; r < 8; r++) ifb.sample[r] = 16'(xs[idx*8+r]);
        ifb.sample_valid = 1'b1;
      end
      if (ifb.sample_valid && ifb.sample_ready === 1'b1) begin
        idx++;
        just = 1'b1;
      end
    end
    check("b_all_transferred", idx, 64'sd16);
    @(negedge clk);
    ifb.sample_valid = 1'b0;
    n = 0;
    while (ifb.cov_valid !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("b_done", ifb.cov_valid, 64'sd1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    ifa.start = 1'b0; ifa.sample_valid = 1'b0; ifa.sample = '0;
    ifb.start = 1'b0; ifb.sample_valid = 1'b0; ifb.sample = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_a_ready", ifa.sample_ready, 64'sd0);
    check("reset_a_valid", ifa.cov_valid, 64'sd0);
    check("reset_a_busy", ifa.busy, 64'sd0);
    check("reset_a_cov_nonzero", (ifa.cov_matrix != '0), 64'sd0);
    check("reset_b_ready", ifb.sample_ready, 64'sd0);
    check("reset_b_valid", ifb.cov_valid, 64'sd0);
    check("reset_b_busy", ifb.busy, 64'sd0);
    check("reset_b_cov_nonzero", (ifb.cov_matrix != '0), 64'sd0);

    run_a('{1, 2, -1, -2, 1, 2, -1, -2}, 0);
    run_a('{3, 5, 3, 5, 3, 5, 3, 5}, 1);
    run_a('{1, 2, -1, -2, 1, 2, -1, -2}, 2);

    // Reset after two of four samples; partial window must vanish.
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    a_feed(100, -50);
    @(negedge clk);
    a_feed(20, 30);
    @(negedge clk);
    ifa.sample_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", ifa.busy, 64'sd0);
    check("midrst_ready", ifa.sample_ready, 64'sd0);
    check("midrst_cov_nonzero", (ifa.cov_matrix != '0), 64'sd0);
    rst = 1'b1;
    @(negedge clk);
    run_a('{7, 1, -3, 4, 2, 2, 5, -8}, 0);

    for (int w = 0; w < 3; w++) run_b();

    check("a_queue_left", exp_a_q.size(), 64'sd0);
    check("b_queue_left", exp_b_q.size(), 64'sd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
